circle_buffer_in: RTL
=====================

Name: circle_buffer_in

Overview:
- Narrow-to-wide gather FIFO; the inverse of the 8-wide-in / 1-wide-out output buffer.
- Accepts one 32-bit pixel word per handshake from the upstream pixel stream.
- Presents 8 consecutive words in parallel to the 8-lane circle/raster datapath.
- Circular queue with read/write pointers and an rts/rtr handshake on both sides.

Parameters:
- DATA_WIDTH, 32, width of each stored word and of each lane.
- DEPTH, 64, number of queue entries; power of two, multiple of 8, minimum 16.
- LOG2DEPTH, 6, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_  input  1  asynchronous active-low reset.
- in_data  input  DATA_WIDTH  incoming pixel word.
- in_rts  input  1  upstream has a word valid.
- in_rtr  output  1  block can accept a word.
- out_px_0 .. out_px_7  output  DATA_WIDTH each  lanes 0..7; lane k = queue[rd_addr+k].
- out_mask  output  8  lane-valid mask; bit k qualifies out_px_k.
- out_rts  output  1  group available.
- out_rtr  input  1  downstream accepts group.
- in_last  input  1  (only with CIRCLE_BUFFER_IN_FLUSH_EN) marks final word of a burst.

Behaviour:
- Reset (async, rst_=0):
  - rd_addr=0, wr_addr=0, flush_pend=0.
  - Outputs: in_rtr=1, out_rts=0, out_mask=8'h00.
  - Queue contents are not cleared.
- Transfers: in_xfc = in_rts & in_rtr; out_xfc = out_rts & out_rtr.
- Occupancy: occ = (wr_addr - rd_addr) mod DEPTH.
  - One slot is reserved, so max occ = DEPTH-1 (63).
- in_rtr = (wr_addr+1 != rd_addr) & !flush_pend.
  - in_rtr must not depend on in_rts.
  - All comparisons use LOG2DEPTH-bit wrap arithmetic.
- On in_xfc: queue[wr_addr] <= in_data; wr_addr <= wr_addr+1.
- out_rts = (occ >= 8), or (flush_pend & occ != 0) when the flush feature is present.
- Lane addressing: out_px_k = queue[(rd_addr+k) mod DEPTH]; combinational read, zero latency.
  - Lanes wrap across the DEPTH-1 -> 0 boundary.
- out_mask = 8'hFF whenever out_rts=1 for a full group; 8'h00 when out_rts=0.
- On out_xfc (full group): rd_addr <= rd_addr+8.
- Simultaneous in_xfc and out_xfc in the same cycle:
  - Both pointer updates apply.
  - The write never aliases a lane being read, because the reserved slot and occ>=8 guarantee it.
- Latency: a word written at edge N is visible on a lane from edge N+1.
  - The 8th word of a group raises out_rts the cycle after its in_xfc.
- Full: occ=63 -> in_rtr=0; rises again the cycle after an out_xfc.
- Empty, or fewer than 8 words with no flush pending: out_rts=0; lane values are don't-care.
- Reset asserted mid-transfer: pointers return to 0 immediately; any partial group is discarded.

Optional Feature:
- Macro: CIRCLE_BUFFER_IN_FLUSH_EN.
- With the macro:
  - Port in_last exists.
  - On in_xfc with in_last=1: flush_addr <= wr_addr+1; flush_pend <= 1.
  - While flush_pend=1:
    - n = min(8, (flush_addr - rd_addr) mod DEPTH).
    - out_rts = (n != 0).
    - out_mask = (1<<n)-1.
    - On out_xfc: rd_addr <= rd_addr+n.
  - flush_pend clears on the out_xfc where rd_addr+n == flush_addr.
  - in_rtr=0 while flush_pend=1.
- Without the macro:
  - No in_last port; flush_pend is tied to 0.
  - Only full groups are emitted; out_mask is 8'hFF or 8'h00.
  - Trailing words (fewer than 8) wait for more input.

Test Plan:
- Reset, then write words 0x00..0x07 with out_rtr=0 -> out_rts=1 after 8th write, out_px_k=k, out_mask=8'hFF; assert out_rtr -> rd_addr=8, out_rts=0.
- Write 63 words with out_rtr=0 -> in_rtr=0 at occ=63; one out_xfc -> occ=55, in_rtr=1 next cycle.
- Pointer wrap: pre-advance rd/wr to 60, write 0xA0..0xA7 -> out_px_0..3 from entries 60..63, out_px_4..7 from 0..3, values 0xA0..0xA7 in order.
- Streaming: in_rts=1 and out_rtr=1 continuously for 64 words -> 8 groups, no word dropped or duplicated, in_rtr never 0.
- Flush (macro on): write 11 words with in_last on the 11th -> first group mask 8'hFF, second group mask 8'h07 with words 8..10; in_rtr=0 until second out_xfc, then flush_pend=0.
- Async reset with occ=5 -> out_rts=0, in_rtr=1, rd_addr=wr_addr=0 without a clock edge.

Source files
------------

// File: rtl/circle_buffer_in_if.sv
// Bus bundle for circle_buffer_in: one-word upstream stream in, 8-lane group out.
// slave  : the buffer's view (takes in_data/in_rts/out_rtr, drives the rest).
// master : the environment's view (drives words and out_rtr, observes lanes).
// in_last exists only when CIRCLE_BUFFER_IN_FLUSH_EN is defined.
interface circle_buffer_in_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_rts;
  logic                  in_rtr;
`ifdef CIRCLE_BUFFER_IN_FLUSH_EN
  logic                  in_last;
`endif
  logic [DATA_WIDTH-1:0] out_px_0;
  logic [DATA_WIDTH-1:0] out_px_1;
  logic [DATA_WIDTH-1:0] out_px_2;
  logic [DATA_WIDTH-1:0] out_px_3;
  logic [DATA_WIDTH-1:0] out_px_4;
  logic [DATA_WIDTH-1:0] out_px_5;
  logic [DATA_WIDTH-1:0] out_px_6;
  logic [DATA_WIDTH-1:0] out_px_7;
  logic [7:0]            out_mask;
  logic                  out_rts;
  logic                  out_rtr;

`ifdef CIRCLE_BUFFER_IN_FLUSH_EN
  modport slave (
    input  in_data, in_rts, in_last, out_rtr,
    output in_rtr, out_px_0, out_px_1, out_px_2, out_px_3,
           out_px_4, out_px_5, out_px_6, out_px_7, out_mask, out_rts
  );
  modport master (
    output in_data, in_rts, in_last, out_rtr,
    input  in_rtr, out_px_0, out_px_1, out_px_2, out_px_3,
           out_px_4, out_px_5, out_px_6, out_px_7, out_mask, out_rts
  );
`else
  modport slave (
    input  in_data, in_rts, out_rtr,
    output in_rtr, out_px_0, out_px_1, out_px_2, out_px_3,
           out_px_4, out_px_5, out_px_6, out_px_7, out_mask, out_rts
  );
  modport master (
    output in_data, in_rts, out_rtr,
    input  in_rtr, out_px_0, out_px_1, out_px_2, out_px_3,
           out_px_4, out_px_5, out_px_6, out_px_7, out_mask, out_rts
  );
`endif
endinterface

// File: rtl/circle_buffer_in.sv
// circle_buffer_in: narrow-to-wide gather FIFO. Accepts one DATA_WIDTH word per
// in_rts/in_rtr handshake and presents 8 consecutive queued words in parallel
// on out_px_0..7 with an out_rts/out_rtr handshake.
// Ports:
//   clk   - clock, rising edge
//   rst_  - asynchronous active-low reset (pointers cleared, queue kept)
//   bus   - circle_buffer_in_if.slave: in_data/in_rts/in_rtr[/in_last],
//           out_px_0..7/out_mask/out_rts/out_rtr
// Optional feature: define CIRCLE_BUFFER_IN_FLUSH_EN to add in_last, which
// flushes a trailing partial group with a reduced out_mask.
module circle_buffer_in #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned LOG2DEPTH  = 6
) (
  input logic               clk,
  input logic               rst_,
  circle_buffer_in_if.slave bus
);

  localparam int unsigned LANES = 8;
  localparam int unsigned CNT_W = 4;

  typedef logic [LOG2DEPTH-1:0] ptr_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] lane_c [LANES];

  ptr_t             rd_q, rd_d;
  ptr_t             wr_q, wr_d;
  ptr_t             occ_c;
  logic             full_c;
  logic             in_rtr_c;
  logic             out_rts_c;
  logic             in_xfc_c;
  logic             out_xfc_c;
  logic [CNT_W-1:0] step_c;
  logic [7:0]       mask_c;
  logic             flush_pend;

`ifdef CIRCLE_BUFFER_IN_FLUSH_EN
  logic flush_pend_q, flush_pend_d;
  ptr_t flush_addr_q, flush_addr_d;
  ptr_t fl_span_c;

  // Flush bookkeeping: remember where the burst ends, hold input until drained.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      flush_pend_q <= 1'b0;
      flush_addr_q <= '0;
    end else begin
      flush_pend_q <= flush_pend_d;
      flush_addr_q <= flush_addr_d;
    end
  end

  always_comb begin
    flush_pend_d = flush_pend_q;
    flush_addr_d = flush_addr_q;
    if (out_xfc_c && flush_pend_q &&
        ((rd_q + LOG2DEPTH'(step_c)) == flush_addr_q)) begin
      flush_pend_d = 1'b0;
    end
    // in_rtr is low while pending, so this never collides with the clear above.
    if (in_xfc_c && bus.in_last) begin
      flush_addr_d = wr_q + LOG2DEPTH'(1);
      flush_pend_d = 1'b1;
    end
  end

  assign flush_pend = flush_pend_q;
  assign fl_span_c  = flush_addr_q - rd_q;
`else
  assign flush_pend = 1'b0;
`endif

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end

  // Queue storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (in_xfc_c) begin
      mem_q[wr_q] <= bus.in_data;
    end
  end

  // Occupancy, handshakes and next pointers; one slot stays empty so full != empty.
  always_comb begin
    occ_c     = wr_q - rd_q;
    full_c    = (wr_q + LOG2DEPTH'(1)) == rd_q;
    in_rtr_c  = !full_c && !flush_pend;
    step_c    = CNT_W'(LANES);
    out_rts_c = occ_c >= LOG2DEPTH'(LANES);
    mask_c    = out_rts_c ? 8'hFF : 8'h00;
`ifdef CIRCLE_BUFFER_IN_FLUSH_EN
    if (flush_pend) begin
      step_c    = (fl_span_c >= LOG2DEPTH'(LANES)) ? CNT_W'(LANES) : CNT_W'(fl_span_c);
      out_rts_c = step_c != CNT_W'(0);
      mask_c    = 8'((9'd1 << step_c) - 9'd1);
    end
`endif
    in_xfc_c  = bus.in_rts && in_rtr_c;
    out_xfc_c = out_rts_c && bus.out_rtr;
    rd_d      = out_xfc_c ? (rd_q + LOG2DEPTH'(step_c)) : rd_q;
    wr_d      = in_xfc_c ? (wr_q + LOG2DEPTH'(1)) : wr_q;
  end

  // Zero-latency lane read; addresses wrap modulo DEPTH.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_c[k] = mem_q[rd_q + LOG2DEPTH'(k)];
    end
  end

  assign bus.in_rtr   = in_rtr_c;
  assign bus.out_rts  = out_rts_c;
  assign bus.out_mask = mask_c;
  assign bus.out_px_0 = lane_c[0];
  assign bus.out_px_1 = lane_c[1];
  assign bus.out_px_2 = lane_c[2];
  assign bus.out_px_3 = lane_c[3];
  assign bus.out_px_4 = lane_c[4];
  assign bus.out_px_5 = lane_c[5];
  assign bus.out_px_6 = lane_c[6];
  assign bus.out_px_7 = lane_c[7];

endmodule
